// File: rtl/regfile_write_sched_if.sv
// Requester-side handshake and register-file write bus for the write-port scheduler.
interface regfile_write_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wr_stall;
  logic [ADDR_W-1:0]         wr_select;
  logic                      wr_enable;
  logic [DATA_W-1:0]         wr_data;
  logic [ID_W-1:0]           grant_id;
  logic                      locked;
  logic [15:0]               write_count;

  modport master (
    output req_valid, req_lock, req_addr, req_data, wr_stall,
    input  req_ready, wr_select, wr_enable, wr_data, grant_id, locked, write_count
  );

  modport slave (
    input  req_valid, req_lock, req_addr, req_data, wr_stall,
    output req_ready, wr_select, wr_enable, wr_data, grant_id, locked, write_count
  );
endinterface

// File: rtl/regfile_write_sched.sv
// Round-robin arbiter for the register file's single write port, with locked
// multi-beat bursts, downstream stall and optional register-0 write suppression.
module regfile_write_sched #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 32,
  parameter bit          ZERO_PROTECT = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  regfile_write_sched_if.slave bus
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t              r_state, w_state_nxt;
  logic [ID_W-1:0]     r_prio, w_prio_nxt;
  logic [ID_W-1:0]     r_owner, w_owner_nxt;
  logic [ADDR_W-1:0]   r_wr_select;
  logic                r_wr_enable;
  logic [DATA_W-1:0]   r_wr_data;
  logic [ID_W-1:0]     r_grant_id;
  logic [15:0]         r_write_count;

  logic [NUM_REQ-1:0]  w_ready;
  logic [ID_W-1:0]     w_sel;
  logic [ID_W-1:0]     w_sel_inc;
  logic                w_accept;
  logic                w_found;
  logic [ADDR_W-1:0]   w_addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   w_data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign w_data_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  assign w_sel_inc = (w_sel == ID_W'(NUM_REQ - 1)) ? '0 : w_sel + ID_W'(1);

  // Grant selection and next-state: round-robin scan in IDLE, owner-only in LOCKED.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    w_ready     = '0;
    w_found     = 1'b0;
    w_sel       = r_prio;
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_owner_nxt = r_owner;

    if (!reset && !bus.wr_stall) begin
      if (r_state == S_LOCKED) begin
        w_sel            = r_owner;
        w_ready[r_owner] = bus.req_valid[r_owner];
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = 32'(r_prio) + 32'(k);
          if (idx >= NUM_REQ) idx = idx - NUM_REQ;
          if (!w_found && bus.req_valid[ID_W'(idx)]) begin
            w_found              = 1'b1;
            w_sel                = ID_W'(idx);
            w_ready[ID_W'(idx)]  = 1'b1;
          end
        end
      end
    end

    w_accept = |(w_ready & bus.req_valid);

    if (w_accept) begin
      if (bus.req_lock[w_sel]) begin
        w_state_nxt = S_LOCKED;
        w_owner_nxt = w_sel;
      end else begin
        w_state_nxt = S_IDLE;
        w_prio_nxt  = w_sel_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_prio  <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // Output stage: one write pulse per accepted beat; commit counter trails it by a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_select   <= '0;
      r_wr_enable   <= 1'b0;
      r_wr_data     <= '0;
      r_grant_id    <= '0;
      r_write_count <= '0;
    end else begin
      r_wr_enable <= 1'b0;
      if (w_accept) begin
        r_wr_select <= w_addr_arr[w_sel];
        r_wr_data   <= w_data_arr[w_sel];
        r_grant_id  <= w_sel;
        r_wr_enable <= !(ZERO_PROTECT && (w_addr_arr[w_sel] == '0));
      end
      if (r_wr_enable) r_write_count <= r_write_count + 16'd1;
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.wr_select   = r_wr_select;
  assign bus.wr_enable   = r_wr_enable;
  assign bus.wr_data     = r_wr_data;
  assign bus.grant_id    = r_grant_id;
  assign bus.locked      = (r_state == S_LOCKED);
  assign bus.write_count = r_write_count;
endmodule
